// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the ID/EX issue logic and the EX-stage
// multiply/divide unit. master = issuing side, slave = ex_muldiv_unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_in;
    logic [1:0]       op_in;
    logic [WIDTH-1:0] rs_data_in;
    logic [WIDTH-1:0] rt_data_in;
    logic             flush_in;
    logic             busy_out;
    logic             done_out;
    logic             div_by_zero_out;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start_in, op_in, rs_data_in, rt_data_in, flush_in,
        input  busy_out, done_out, div_by_zero_out, hi_out, lo_out
    );

    modport slave (
        input  start_in, op_in, rs_data_in, rt_data_in, flush_in,
        output busy_out, done_out, div_by_zero_out, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: WIDTH-step shift-add / restoring divide on magnitudes,
// one sign-fix cycle, HI/LO written on FIX->DONE. Define MULDIV_DIV_EN to include the divider.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign in_signed = ~bus.op_in[0];
    assign a_mag = (in_signed && bus.rs_data_in[WIDTH-1]) ? -bus.rs_data_in : bus.rs_data_in;
    assign b_mag = (in_signed && bus.rt_data_in[WIDTH-1]) ? -bus.rt_data_in : bus.rt_data_in;

    // Multiply: acc = {partial, multiplier}; add multiplicand on the LSB, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
    logic [WIDTH:0] div_part, div_diff;

    // Divide: acc = {remainder, dividend/quotient}; a clean subtract shifts in a 1.
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opnd_q};
    assign div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`else
    localparam bit DIV_EN = 1'b0;
    assign div_next = '0;
`endif

    assign prod_fix = qsign_q ? -acc_q : acc_q;
    assign quot_fix = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start_in && !bus.flush_in) begin
                    op_d    = bus.op_in;
                    qsign_d = in_signed && (bus.rs_data_in[WIDTH-1] ^ bus.rt_data_in[WIDTH-1]);
                    rsign_d = in_signed && bus.rs_data_in[WIDTH-1];
                    cnt_d   = '0;
                    if (bus.op_in[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        if (!DIV_EN) begin
                            state_d = S_DONE;
                        end else if (bus.rt_data_in == '0) begin
                            state_d = S_DONE;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        opnd_d  = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = (DIV_EN && op_q[1]) ? div_next : mul_next;
                    if (cnt_q == LAST_STEP) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (DIV_EN && op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy_out        = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done_out        = (state_q == S_DONE);
    assign bus.div_by_zero_out = dz_q;
    assign bus.hi_out          = hi_q;
    assign bus.lo_out          = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed + randomized bench for ex_muldiv_unit; expectations come from plain 64-bit
// arithmetic on the operands. Honours MULDIV_DIV_EN the same way the design does.
module tb_ex_muldiv_unit;
    localparam int WIDTH = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int checks   = 0;
    int failures = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    ex_muldiv_if #(.WIDTH(WIDTH)) bus ();
    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO/flag/latency should be for one issued operation.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int lat);
        logic [63:0] p;
        longint sa, sb;
        hi = hi_m;
        lo = lo_m;
        dz = 1'b0;
        lat = 34;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = 64'(sa * sb); {hi, lo} = p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
            default: begin
                if (!DIV_EN) begin
                    lat = 1;
                end else if (b == 32'd0) begin
                    lat = 1;
                    dz = 1'b1;
                end else if (op == 2'd2) begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_in   = 1'b1;
        bus.op_in      = op;
        bus.rs_data_in = a;
        bus.rt_data_in = b;
        @(negedge clk);
        bus.start_in   = 1'b0;
    endtask

    // Called in the first cycle after the start edge; lat=1 means done in that cycle.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (bus.done_out !== 1'b1 && lat < 100) begin
            if (bus.busy_out === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic edz;
        int elat, lat, bc;
        model(op, a, b, eh, el, edz, elat);
        issue(op, a, b);
        wait_done(lat, bc);
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(elat - 1));
        check({tag, "_dz"}, bus.div_by_zero_out, edz);
        check({tag, "_hi"}, bus.hi_out, eh);
        check({tag, "_lo"}, bus.lo_out, el);
        $display("txn %s op=%0d a=%08h b=%08h lat=%0d hi=%08h lo=%08h dz=%0b",
                 tag, op, a, b, lat, bus.hi_out, bus.lo_out, bus.div_by_zero_out);
        hi_m = eh;
        lo_m = el;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, bus.done_out, 1'b0);
        check({tag, "_dz_one_cycle"}, bus.div_by_zero_out, 1'b0);
    endtask

    initial begin
        int lat, bc, seen;
        logic [31:0] eh, el, ra, rb;
        logic edz;
        int elat;
        logic [1:0] rop;

        rst = 1'b1;
        bus.start_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.op_in = 2'd0;
        bus.rs_data_in = '0;
        bus.rt_data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", bus.hi_out, 32'h0);
        check("rst_lo", bus.lo_out, 32'h0);
        check("rst_busy", bus.busy_out, 1'b0);
        check("rst_done", bus.done_out, 1'b0);
        check("rst_dz", bus.div_by_zero_out, 1'b0);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0 || bus.div_by_zero_out !== 1'b0) seen = 1;
        end
        check("idle_quiet", 64'(seen), 64'd0);
        check("idle_hi", bus.hi_out, 32'h0);
        check("idle_lo", bus.lo_out, 32'h0);

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi_const", bus.hi_out, 32'hFFFFFFFE);
        check("multu_max_lo_const", bus.lo_out, 32'h00000001);
        run_op("mult_m3x7", 2'd0, 32'hFFFFFFFD, 32'h00000007);
        check("mult_m3x7_hi_const", bus.hi_out, 32'hFFFFFFFF);
        check("mult_m3x7_lo_const", bus.lo_out, 32'hFFFFFFEB);
        run_op("mult_min", 2'd0, 32'h80000000, 32'h80000000);
        check("mult_min_hi_const", bus.hi_out, 32'h40000000);
        check("mult_min_lo_const", bus.lo_out, 32'h00000000);
`ifdef MULDIV_DIV_EN
        run_op("div_m7by2", 2'd2, 32'hFFFFFFF9, 32'h00000002);
        check("div_m7by2_lo_const", bus.lo_out, 32'hFFFFFFFD);
        check("div_m7by2_hi_const", bus.hi_out, 32'hFFFFFFFF);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo_const", bus.lo_out, 32'h80000000);
        check("div_ovf_hi_const", bus.hi_out, 32'h00000000);
        run_op("divu_preload", 2'd3, 32'h00002211, 32'h00000100);
        run_op("divu_by0", 2'd3, 32'd100, 32'd0);
        check("divu_by0_hi_const", bus.hi_out, 32'h11);
        check("divu_by0_lo_const", bus.lo_out, 32'h22);
`else
        run_op("div_nodiv", 2'd2, 32'd10, 32'd3);
        check("div_nodiv_hi_const", bus.hi_out, 32'h40000000);
        check("div_nodiv_lo_const", bus.lo_out, 32'h00000000);
        run_op("multu_3x4", 2'd1, 32'd3, 32'd4);
        check("multu_3x4_lo_const", bus.lo_out, 32'd12);
        check("multu_3x4_hi_const", bus.hi_out, 32'd0);
`endif

        // start_in mid-CALC must be ignored; then a back-to-back start in the DONE cycle.
        model(2'd1, 32'd3, 32'd4, eh, el, edz, elat);
        issue(2'd1, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        bus.start_in = 1'b1;
        bus.op_in = 2'd0;
        bus.rs_data_in = 32'd7;
        bus.rt_data_in = 32'd7;
        @(negedge clk);
        bus.start_in = 1'b0;
        wait_done(lat, bc);
        check("ignore_start_latency", 64'(lat + 5), 64'd34);
        check("ignore_start_hi", bus.hi_out, eh);
        check("ignore_start_lo", bus.lo_out, el);
        $display("txn ignore_start op=1 a=3 b=4 hi=%08h lo=%08h", bus.hi_out, bus.lo_out);
        hi_m = eh;
        lo_m = el;
        run_op("back_to_back", 2'd0, 32'hFFFF1234, 32'h00ABCDEF);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = 32'($urandom);
            endcase
            run_op("rand", rop, ra, rb);
        end

        // Flush at CALC step 10 discards the multiply.
        issue(2'd0, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        check("flush_busy_before", bus.busy_out, 1'b1);
        bus.flush_in = 1'b1;
        @(negedge clk);
        bus.flush_in = 1'b0;
        check("flush_busy_drop", bus.busy_out, 1'b0);
        seen = 0;
        repeat (40) begin
            if (bus.done_out !== 1'b0) seen = 1;
            @(negedge clk);
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hi_kept", bus.hi_out, hi_m);
        check("flush_lo_kept", bus.lo_out, lo_m);
        $display("txn flush op=0 a=5 b=6 hi=%08h lo=%08h", bus.hi_out, bus.lo_out);

        // Flush together with start in IDLE drops the start.
        bus.flush_in = 1'b1;
        issue(2'd1, 32'd2, 32'd2);
        bus.flush_in = 1'b0;
        check("flush_start_busy", bus.busy_out, 1'b0);
        check("flush_start_done", bus.done_out, 1'b0);
        $display("txn flush_start op=1 a=2 b=2 busy=%0b", bus.busy_out);
        run_op("after_flush", 2'd1, 32'h12345678, 32'h9ABCDEF0);

        // Reset mid-operation clears HI/LO and abandons the operation.
        issue(2'd1, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hi", bus.hi_out, 32'h0);
        check("midrst_lo", bus.lo_out, 32'h0);
        check("midrst_busy", bus.busy_out, 1'b0);
        seen = 0;
        repeat (40) begin
            if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) seen = 1;
            @(negedge clk);
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        $display("txn midrst op=1 a=9 b=9 hi=%08h lo=%08h", bus.hi_out, bus.lo_out);
        hi_m = '0;
        lo_m = '0;
        run_op("post_reset", 2'd0, 32'hFFFFFFFF, 32'h00000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
